// File: rtl/snn_uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : snn_uart_byte_rx
//  Description : UART 8N1 byte receiver for the SNN accelerator host link.
//                Emits a one-cycle valid pulse per framed byte and a
//                one-cycle pulse per framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_uart_byte_rx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int c_CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_FULL = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BAUD_HALF = c_CNT_W'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]         r_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_rx_d;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic               w_tick;

    assign w_tick  = (r_baud_cnt == '0);
    assign rx_busy = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_d     <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'h00;
            rx_data    <= 8'h00;
            rx_rdy     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // Only a genuine 1->0 edge starts a frame, so a held-low break cannot retrigger.
                    if (r_rx_d && !r_rx_s) begin
                        r_state    <= c_START;
                        r_baud_cnt <= c_BAUD_HALF;
                    end
                end
                c_START: begin
                    if (w_tick) begin
                        if (!r_rx_s) begin
                            r_state    <= c_DATA;
                            r_baud_cnt <= c_BAUD_FULL;
                            r_bit_cnt  <= 3'd0;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_shreg    <= {r_rx_s, r_shreg[7:1]};
                        r_baud_cnt <= c_BAUD_FULL;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                c_STOP: begin
                    // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
                    if (w_tick) begin
                        if (r_rx_s) begin
                            rx_data <= r_shreg;
                            rx_rdy  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= c_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snn_uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_uart_byte_rx
//  Description : Directed self-checking bench for snn_uart_byte_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_uart_byte_rx;

    localparam int c_BAUD = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frame_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;

    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    logic r_prev_rdy = 1'b0;
    logic r_prev_err = 1'b0;

    snn_uart_byte_rx #(.BAUD_DIV(c_BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_rdy)              rdy_cnt  <= rdy_cnt + 1;
        if (frame_err)           err_cnt  <= err_cnt + 1;
        if (rx_busy)             busy_cnt <= busy_cnt + 1;
        if (rx_rdy && frame_err) both_cnt <= both_cnt + 1;
        if ((rx_rdy && r_prev_rdy) || (frame_err && r_prev_err)) long_cnt <= long_cnt + 1;
        r_prev_rdy <= rx_rdy;
        r_prev_err <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, c_BAUD);
        for (int i = 0; i < 8; i++) hold(b[i], c_BAUD);
        hold(stop_bit, c_BAUD);
    endtask

    int base_rdy;
    int base_err;
    int base_busy;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_rdy", 32'(rx_rdy), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_rx_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        hold(1'b1, 10);

        // 1: clean 0xA5
        base_rdy = rdy_cnt; base_err = err_cnt;
        send_byte(8'hA5, 1'b1);
        hold(1'b1, 8);
        chk("a5_rdy_pulses", 32'(rdy_cnt - base_rdy), 32'd1);
        chk("a5_err_pulses", 32'(err_cnt - base_err), 32'd0);
        chk("a5_rx_data", 32'(rx_data), 32'hA5);
        chk("a5_busy_after", 32'(rx_busy), 32'h0);

        // 4: bad stop bit on 0x3C, then 0x5A
        base_rdy = rdy_cnt; base_err = err_cnt;
        send_byte(8'h3C, 1'b0);
        hold(1'b1, 32);
        chk("3c_err_pulses", 32'(err_cnt - base_err), 32'd1);
        chk("3c_rdy_pulses", 32'(rdy_cnt - base_rdy), 32'd0);
        chk("3c_rx_data_kept", 32'(rx_data), 32'hA5);
        send_byte(8'h5A, 1'b1);
        hold(1'b1, 8);
        chk("5a_rdy_pulses", 32'(rdy_cnt - base_rdy), 32'd1);
        chk("5a_rx_data", 32'(rx_data), 32'h5A);

        // 2: back-to-back 0x00 and 0xFF
        base_rdy = rdy_cnt;
        send_byte(8'h00, 1'b1);
        chk("b2b_first_rdy", 32'(rdy_cnt - base_rdy), 32'd1);
        chk("b2b_first_data", 32'(rx_data), 32'h00);
        send_byte(8'hFF, 1'b1);
        hold(1'b1, 8);
        chk("b2b_second_rdy", 32'(rdy_cnt - base_rdy), 32'd2);
        chk("b2b_second_data", 32'(rx_data), 32'hFF);

        // 3: 4-clk glitch rejected
        base_rdy = rdy_cnt; base_err = err_cnt; base_busy = busy_cnt;
        hold(1'b0, 4);
        hold(1'b1, 40);
        chk("glitch_busy_window", 32'((busy_cnt - base_busy >= 1) && (busy_cnt - base_busy <= 10)), 32'h1);
        chk("glitch_busy_low", 32'(rx_busy), 32'h0);
        chk("glitch_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        chk("glitch_no_err", 32'(err_cnt - base_err), 32'd0);
        chk("glitch_data_kept", 32'(rx_data), 32'hFF);

        // 5: reset mid-DATA of 0x81 (during bit0, line high)
        base_rdy = rdy_cnt; base_err = err_cnt;
        hold(1'b0, c_BAUD);
        hold(1'b1, 8);
        chk("mid_data_busy", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_busy", 32'(rx_busy), 32'h0);
        chk("rst_rx_rdy", 32'(rx_rdy), 32'h0);
        hold(1'b1, 200);
        chk("rst_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        chk("rst_no_err", 32'(err_cnt - base_err), 32'd0);
        send_byte(8'h81, 1'b1);
        hold(1'b1, 8);
        chk("81_rdy_pulses", 32'(rdy_cnt - base_rdy), 32'd1);
        chk("81_rx_data", 32'(rx_data), 32'h81);

        // 6: 40-bit break, then 0x7E
        base_rdy = rdy_cnt; base_err = err_cnt;
        hold(1'b0, 40 * c_BAUD);
        chk("break_err_pulses", 32'(err_cnt - base_err), 32'd1);
        chk("break_busy_low", 32'(rx_busy), 32'h0);
        hold(1'b1, 32);
        chk("break_err_after_release", 32'(err_cnt - base_err), 32'd1);
        chk("break_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        send_byte(8'h7E, 1'b1);
        hold(1'b1, 8);
        chk("7e_rdy_pulses", 32'(rdy_cnt - base_rdy), 32'd1);
        chk("7e_rx_data", 32'(rx_data), 32'h7E);

        chk("never_both_pulses", 32'(both_cnt), 32'd0);
        chk("pulses_single_cycle", 32'(long_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
